interrupt_sequencer: RTL and testbench
======================================

# interrupt_sequencer

Sequential front end for the CPU interrupt path on the ODS-MR control CPLD. It synchronizes and debounces the raw power and reset buttons and detects the event edge selected by ATX mode. It latches watchdog and button events into sticky status bits 6:4 with write-1-to-clear, and drives the open-drain, active-low CPU interrupt line through a small assert/re-arm state machine. The re-arm gap guarantees the CPU sees a fresh falling edge whenever events remain pending after a clear.

## Interface
- DB_CNT, 1000: debounce stable-cycle count, about 30 ms at 32.768 kHz; counter width is clog2(DB_CNT+1).
- REARM_GAP, 4: cycles the line is released between a clear and reassertion for still-pending status; minimum 1.
- CLK32768  in  1  free-running 32.768 kHz clock.
- ResetN  in  1  asynchronous active-low reset.
- PwrButtonN  in  1  raw power button, asynchronous, low = pressed.
- RstButtonN  in  1  raw reset button, asynchronous, low = pressed.
- WatchDogIREQ  in  1  watchdog request level, asynchronous.
- ATX  in  1  event polarity select: 1 = event on release (rising), 0 = event on press (falling).
- EnableInt  in  3  per-source enable, ordered {WDT, RST, PWR}.
- IntRegWr  in  1  one-cycle write strobe to interrupt register 0x09.
- IntRegWrData  in  3  write data bits 6:4; a 1 clears the matching status bit.
- IntStatus  out  3  sticky status {WDT, RST, PWR} = register bits 6:4.
- InterruptD  out  1  CPU interrupt, 1'b0 when asserted, 1'bz otherwise.
- IntActive  out  1  internal copy of assertion, 1 = driving low.

## Operation
- Each button: 2-FF synchronizer, then debounce. The debounced level changes only after DB_CNT consecutive cycles of a new sampled value; any bounce restarts the count.
- Edge detect on each debounced level. ATX=1 selects the rising edge (release); ATX=0 selects the falling edge (press). ATX is sampled on the edge cycle.
- WatchDogIREQ: 2-FF synchronizer with no debounce; a rising edge sets the WDT bit.
- Status bit set: the cycle after the qualified edge. Bits stay set until cleared.
- Clear: on IntRegWr, each bit with IntRegWrData=1 clears. Clearing a bit that is not set has no effect.
- Set and clear of the same bit in the same cycle: set wins and the bit stays 1.
- pending = |(IntStatus & EnableInt).
- FSM states:
  - IDLE: line released. Go to ASSERT when pending.
  - ASSERT: line driven low. Go to GAP on any IntRegWr that clears at least one enabled bit. Go to IDLE if pending drops for any other reason, such as the enable being removed.
  - GAP: line released, counts REARM_GAP cycles. At the end, go to ASSERT if pending, else IDLE. New events arriving during GAP are held in status and are not lost.
- Reset values: IntStatus=3'b000, IntActive=0, InterruptD=z, FSM=IDLE. Synchronizers and debounced levels reset to 1 (released), so no edge is detected on reset exit.
- Reset asserted mid-operation clears all status and counters immediately.

## Timing
- Button press to status set: 2 (sync) + DB_CNT + 1 (edge) + 1 (latch) cycles, ±1 for sampling phase.
- Watchdog edge to status set: 3 cycles.
- Status set with enable to InterruptD low: 1 cycle.
- Clear write to InterruptD release: 1 cycle. Reassertion, if still pending: REARM_GAP cycles after release.
- EnableInt change: takes effect on pending in the same cycle and on the line on the next edge.

## Configuration
- INT_DEBOUNCE_EN defined: debounce counters instantiated as described.
- INT_DEBOUNCE_EN undefined: the debounced level is the synchronizer output, so press-to-status latency is 4 cycles, DB_CNT is ignored, and no counters are synthesized.

## Structure
- Package ods_int_pkg holds:
  - bit indices INT_BIT_WDT=6, INT_BIT_RST=5, INT_BIT_PWR=4;
  - the FSM state encoding (IDLE, ASSERT, GAP);
  - the 0x09 register address constant.
- Sub-module button_debounce (synchronizer + counter + debounced level + rise/fall pulses), instantiated twice. It contains the INT_DEBOUNCE_EN switch.

## Test plan
- Reset release with buttons idle: IntStatus=000, InterruptD=z, and no status set during 2*DB_CNT cycles.
- ATX=0, EnableInt=010, RstButtonN held low for DB_CNT+5 cycles with 3-cycle bounce at the start: exactly one RST set, DB_CNT+4 ±1 cycles after the last bounce; InterruptD=0 one cycle later.
- ATX=1, PWR press then release: no set on press; PWR set after release plus DB_CNT+4 cycles.
- WDT and PWR both set, EnableInt=111, write 3'b100: line released next cycle, reasserted REARM_GAP cycles later, IntStatus=001.
- Watchdog edge arriving in the same cycle as a write clearing WDT: bit remains 1 and the line reasserts after the gap.
- ResetN pulsed low while in ASSERT with status 111: IntStatus=000 and InterruptD=z asynchronously.

Source files
------------

// File: rtl/ods_int_pkg.sv
// Shared definitions for the ODS-MR interrupt path: register 0x09 bit map and sequencer states.
package ods_int_pkg;

    localparam int INT_BIT_WDT  = 6;
    localparam int INT_BIT_RST  = 5;
    localparam int INT_BIT_PWR  = 4;
    localparam int INT_BIT_BASE = INT_BIT_PWR;

    localparam logic [7:0] INT_REG_ADDR = 8'h09;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } int_state_t;

    // Position of a register-0x09 bit inside the 3-bit status vector.
    function automatic int status_idx(input int reg_bit);
        return reg_bit - INT_BIT_BASE;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Button synchronizer + debounce with registered rise/fall pulses; INT_DEBOUNCE_EN enables the counter.
// Latency raw->pulse: 3 + DB_CNT cycles (3 without INT_DEBOUNCE_EN); no backpressure.
module button_debounce
    import ods_int_pkg::*;
#(
    parameter int DB_CNT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_d;

    // Reset to released so leaving reset with idle buttons produces no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef INT_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CNT + 1);

    logic [CW-1:0] cnt;
    logic          db_level;

    // Any sample matching the current level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            db_level <= 1'b1;
        end else if (sync2 == db_level) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CNT - 1)) begin
            cnt      <= '0;
            db_level <= sync2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = db_level;
`else
    assign level = sync2;

    if (DB_CNT < 1) begin : g_db_cnt_ignored
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b1;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            level_d <= level;
            rise    <= level & ~level_d;
            fall    <= ~level & level_d;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// CPU interrupt front end: button/watchdog event capture, W1C status bits 6:4, open-drain IRQ with re-arm gap.
// Latency: status set -> line low 1 cycle, clear -> release 1 cycle; debounce depth set by INT_DEBOUNCE_EN.
module interrupt_sequencer
    import ods_int_pkg::*;
#(
    parameter int DB_CNT    = 1000,
    parameter int REARM_GAP = 4
) (
    input  logic       CLK32768,
    input  logic       ResetN,
    input  logic       PwrButtonN,
    input  logic       RstButtonN,
    input  logic       WatchDogIREQ,
    input  logic       ATX,
    input  logic [2:0] EnableInt,
    input  logic       IntRegWr,
    input  logic [2:0] IntRegWrData,
    output logic [2:0] IntStatus,
    output wire        InterruptD,
    output logic       IntActive
);

    localparam int B_WDT = status_idx(INT_BIT_WDT);
    localparam int B_RST = status_idx(INT_BIT_RST);
    localparam int B_PWR = status_idx(INT_BIT_PWR);
    localparam int GW    = $clog2(REARM_GAP + 1);

    logic pwr_rise, pwr_fall;
    logic rst_rise, rst_fall;
    logic wdt_s1, wdt_s2, wdt_d;
    logic wdt_rise;
    logic [2:0] set_vec;
    logic [2:0] clr_vec;
    logic       pending;
    logic       clr_hit;
    int_state_t state;
    logic [GW-1:0] gap_cnt;

    button_debounce #(.DB_CNT(DB_CNT)) u_pwr_db (
        .clk   (CLK32768),
        .rst_n (ResetN),
        .raw   (PwrButtonN),
        .rise  (pwr_rise),
        .fall  (pwr_fall)
    );

    button_debounce #(.DB_CNT(DB_CNT)) u_rst_db (
        .clk   (CLK32768),
        .rst_n (ResetN),
        .raw   (RstButtonN),
        .rise  (rst_rise),
        .fall  (rst_fall)
    );

    always_ff @(posedge CLK32768 or negedge ResetN) begin
        if (!ResetN) begin
            wdt_s1 <= 1'b0;
            wdt_s2 <= 1'b0;
            wdt_d  <= 1'b0;
        end else begin
            wdt_s1 <= WatchDogIREQ;
            wdt_s2 <= wdt_s1;
            wdt_d  <= wdt_s2;
        end
    end

    assign wdt_rise = wdt_s2 & ~wdt_d;

    always_comb begin
        set_vec        = '0;
        set_vec[B_WDT] = wdt_rise;
        set_vec[B_RST] = ATX ? rst_rise : rst_fall;
        set_vec[B_PWR] = ATX ? pwr_rise : pwr_fall;
    end

    assign clr_vec = IntRegWr ? IntRegWrData : 3'b000;
    assign pending = |(IntStatus & EnableInt);
    // A bit being set in the clearing cycle counts as cleared-and-reset, so it earns a fresh edge.
    assign clr_hit = |(clr_vec & EnableInt & (IntStatus | set_vec));

    // Set wins over a simultaneous clear of the same bit.
    always_ff @(posedge CLK32768 or negedge ResetN) begin
        if (!ResetN) begin
            IntStatus <= 3'b000;
        end else begin
            IntStatus <= (IntStatus & ~clr_vec) | set_vec;
        end
    end

    always_ff @(posedge CLK32768 or negedge ResetN) begin
        if (!ResetN) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            IntActive <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        state     <= ASSERT;
                        IntActive <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (clr_hit) begin
                        state     <= GAP;
                        gap_cnt   <= '0;
                        IntActive <= 1'b0;
                    end else if (!pending) begin
                        state     <= IDLE;
                        IntActive <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(REARM_GAP - 1)) begin
                        state     <= pending ? ASSERT : IDLE;
                        IntActive <= pending;
                        gap_cnt   <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    IntActive <= 1'b0;
                end
            endcase
        end
    end

    assign InterruptD = IntActive ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer; expected latencies follow the INT_DEBOUNCE_EN build setting.
module tb_interrupt_sequencer;

    localparam int DB  = 8;
    localparam int GAP = 4;
`ifdef INT_DEBOUNCE_EN
    localparam int LAT = DB + 4;
`else
    localparam int LAT = 4;
`endif

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       pwr_n     = 1'b1;
    logic       rst_btn_n = 1'b1;
    logic       wdt       = 1'b0;
    logic       atx       = 1'b0;
    logic [2:0] en        = 3'b000;
    logic       wr        = 1'b0;
    logic [2:0] wdat      = 3'b000;
    logic [2:0] status;
    logic       active;
    wire        int_d;

    pullup (int_d);

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    interrupt_sequencer #(.DB_CNT(DB), .REARM_GAP(GAP)) dut (
        .CLK32768     (clk),
        .ResetN       (rst_n),
        .PwrButtonN   (pwr_n),
        .RstButtonN   (rst_btn_n),
        .WatchDogIREQ (wdt),
        .ATX          (atx),
        .EnableInt    (en),
        .IntRegWr     (wr),
        .IntRegWrData (wdat),
        .IntStatus    (status),
        .InterruptD   (int_d),
        .IntActive    (active)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_status(input int b, input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (status[b]) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_active(input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (active) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic write_clr(input logic [2:0] d);
        wr   = 1'b1;
        wdat = d;
        tick();
        wr   = 1'b0;
        wdat = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;

        #2;
        check_val("reset_status", 32'(status), 32'h0);
        check_val("reset_active", 32'(active), 32'h0);
        check_val("reset_line", 32'(int_d), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        ticks(2 * DB);
        check_val("idle_status", 32'(status), 32'h0);
        check_val("idle_line", 32'(int_d), 32'h1);

        // Reset-button press with ATX=0
        atx = 1'b0;
        en  = 3'b010;
`ifdef INT_DEBOUNCE_EN
        rst_btn_n = 1'b0;
        tick();
        rst_btn_n = 1'b1;
        tick();
        rst_btn_n = 1'b0;
`else
        rst_btn_n = 1'b0;
`endif
        wait_status(1, LAT + 6, lat);
        check_val("rst_latency", 32'(lat), 32'(LAT));
        check_val("rst_only", 32'(status), 32'h2);
        tick();
        check_val("rst_active", 32'(active), 32'h1);
        check_val("rst_line_low", 32'(int_d), 32'h0);
        rst_btn_n = 1'b1;
        ticks(LAT + 2);
        check_val("rst_release_no_set", 32'(status), 32'h2);
        write_clr(3'b010);
        check_val("clr_release", 32'(active), 32'h0);
        check_val("clr_status", 32'(status), 32'h0);
        ticks(GAP + 1);
        check_val("no_rearm_empty", 32'(active), 32'h0);

        // Power button with ATX=1: event on release only
        atx   = 1'b1;
        en    = 3'b001;
        pwr_n = 1'b0;
        ticks(LAT + 4);
        check_val("pwr_press_none", 32'(status), 32'h0);
        pwr_n = 1'b1;
        wait_status(0, LAT + 6, lat);
        check_val("pwr_release_latency", 32'(lat), 32'(LAT));
        tick();
        check_val("pwr_active", 32'(active), 32'h1);

        // Watchdog edge, then clear WDT with PWR still pending
        en  = 3'b111;
        wdt = 1'b1;
        wait_status(2, 8, lat);
        check_val("wdt_latency", 32'(lat), 32'h3);
        check_val("wdt_pwr_status", 32'(status), 32'h5);
        tick();
        write_clr(3'b100);
        check_val("gap_release", 32'(active), 32'h0);
        check_val("gap_line", 32'(int_d), 32'h1);
        check_val("gap_status", 32'(status), 32'h1);
        wait_active(GAP + 4, lat);
        check_val("rearm_gap", 32'(lat), 32'(GAP));
        check_val("rearm_line", 32'(int_d), 32'h0);
        wdt = 1'b0;
        ticks(4);

        // Watchdog set coinciding with a write clearing WDT
        wdt = 1'b1;
        tick();
        tick();
        wr   = 1'b1;
        wdat = 3'b100;
        tick();
        wr   = 1'b0;
        wdat = 3'b000;
        check_val("same_cycle_status", 32'(status), 32'h5);
        check_val("same_cycle_release", 32'(active), 32'h0);
        wait_active(GAP + 4, lat);
        check_val("same_cycle_rearm", 32'(lat), 32'(GAP));

        // Enable removal drops the line, restoring it reasserts
        en = 3'b000;
        tick();
        check_val("en_off_release", 32'(active), 32'h0);
        en = 3'b111;
        tick();
        check_val("en_on_assert", 32'(active), 32'h1);

        // Build 111, then asynchronous reset while asserted
        atx       = 1'b0;
        rst_btn_n = 1'b0;
        wait_status(1, LAT + 6, lat);
        check_val("all_set", 32'(status), 32'h7);
        rst_btn_n = 1'b1;
        wdt       = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_val("async_rst_status", 32'(status), 32'h0);
        check_val("async_rst_active", 32'(active), 32'h0);
        check_val("async_rst_line", 32'(int_d), 32'h1);
        ticks(2);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(LAT + 4);
        check_val("post_rst_quiet", 32'(status), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
